// File: rtl/nios_qsys_oci_debug_ram.sv
// JTAG-side debug RAM stage: executes address-load / read / write commands from the
// debug module against a word-addressed RAM shared with an Avalon-MM CPU slave port.
module nios_qsys_oci_debug_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg
);

    typedef enum logic {
        PH_IDLE    = 1'b0,
        PH_RD_WAIT = 1'b1
    } phase_e;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [31:0]       mem_q [2**ADDR_W];
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic              pend_q, pend_d;
    logic              jrd_q, jrd_d;
    phase_e            phase_q, phase_d;

    logic              jtag_we_s, jtag_re_s, jtag_op_s;
    logic              cpu_we_s, cpu_re_s, waitreq_s;
    logic              ram_we_s, ram_re_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [31:0]       ram_wdata_s;
    logic [3:0]        ram_be_s;
    logic              unused_jdo_s;

    assign unused_jdo_s = ^{jdo[37:36], jdo[2:0]};

    // JTAG command decode: write beats read beats address load; reads/writes post-increment.
    always_comb begin
        mon_a_d   = mon_a_q;
        pend_d    = 1'b0;
        jtag_we_s = 1'b0;
        jtag_re_s = 1'b0;
        if (take_action_ocimem_b) begin
            jtag_we_s = 1'b1;
            mon_a_d   = mon_a_q + ADDR_ONE;
        end else if (take_no_action_ocimem_a) begin
            jtag_re_s = 1'b1;
            mon_a_d   = mon_a_q + ADDR_ONE;
        end else begin
            // A read-after-load issues one cycle after the load and advances like a normal read.
            if (pend_q) begin
                jtag_re_s = 1'b1;
                mon_a_d   = mon_a_q + ADDR_ONE;
            end else begin
                jtag_re_s = 1'b0;
            end
            if (take_action_ocimem_a) begin
                mon_a_d = jdo[17 +: ADDR_W];
                pend_d  = jdo[35];
            end else begin
                pend_d  = 1'b0;
            end
        end
        jrd_d     = jtag_re_s;
        jtag_op_s = jtag_we_s | jtag_re_s;
    end

    // CPU port: any JTAG RAM access in IDLE stalls the CPU; RD_WAIT never touches the RAM.
    always_comb begin
        phase_d   = phase_q;
        waitreq_s = 1'b0;
        cpu_we_s  = 1'b0;
        cpu_re_s  = 1'b0;
        case (phase_q)
            PH_IDLE: begin
                if ((avs_read | avs_write) && jtag_op_s) begin
                    waitreq_s = 1'b1;
                end else if (avs_read) begin
                    cpu_re_s  = 1'b1;
                    waitreq_s = 1'b1;
                    phase_d   = PH_RD_WAIT;
                end else if (avs_write) begin
                    cpu_we_s  = 1'b1;
                end else begin
                    waitreq_s = 1'b0;
                end
            end
            PH_RD_WAIT: begin
                phase_d = PH_IDLE;
            end
            default: begin
                phase_d = PH_IDLE;
            end
        endcase
    end

    // RAM port steering; JTAG and CPU accesses are mutually exclusive by construction.
    always_comb begin
        ram_we_s    = jtag_we_s | cpu_we_s;
        ram_re_s    = jtag_re_s | cpu_re_s;
        if (jtag_op_s) begin
            ram_addr_s  = mon_a_q;
            ram_wdata_s = jdo[34:3];
            ram_be_s    = 4'hF;
        end else begin
            ram_addr_s  = avs_address;
            ram_wdata_s = avs_writedata;
            ram_be_s    = avs_byteenable;
        end
        if (jrd_q) begin
            mon_d_d = rdata_q;
        end else begin
            mon_d_d = mon_d_q;
        end
    end

    // RAM array with per-byte write enables; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int j = 0; j < 4; j++) begin
                if (ram_be_s[j]) begin
                    mem_q[ram_addr_s][8*j +: 8] <= ram_wdata_s[8*j +: 8];
                end
            end
        end
    end

    // Synchronous RAM read register, shared by the JTAG capture and the CPU read path.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'h0000_0000;
        end else if (ram_re_s) begin
            rdata_q <= mem_q[ram_addr_s];
        end
    end

    // Control state; reset drops any in-flight JTAG read and abandons a CPU read.
    always_ff @(posedge clk) begin
        if (reset) begin
            mon_a_q <= '0;
            mon_d_q <= 32'h0000_0000;
            pend_q  <= 1'b0;
            jrd_q   <= 1'b0;
            phase_q <= PH_IDLE;
        end else begin
            mon_a_q <= mon_a_d;
            mon_d_q <= mon_d_d;
            pend_q  <= pend_d;
            jrd_q   <= jrd_d;
            phase_q <= phase_d;
        end
    end

    assign MonDReg         = mon_d_q;
    assign MonAReg         = mon_a_q;
    assign avs_readdata    = rdata_q;
    assign avs_waitrequest = waitreq_s;

endmodule

// File: tb/tb_nios_qsys_oci_debug_ram.sv
// Scoreboard bench for nios_qsys_oci_debug_ram: directed scenarios plus randomized
// JTAG/CPU traffic checked against an array model of the debug RAM.
module tb_nios_qsys_oci_debug_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;

    nios_qsys_oci_debug_ram #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
        .MonDReg(MonDReg), .MonAReg(MonAReg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] val;
    } jexp_t;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    logic [31:0] mm [256];
    logic [7:0]  m_a;
    logic [31:0] exp_mond;
    jexp_t       jq[$];
    logic [31:0] cq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: retires due JTAG reads into the expected MonDReg and pops CPU read data.
    always @(negedge clk) begin
        if (mon_en) begin
            while (jq.size() > 0 && jq[0].due <= cyc) begin
                exp_mond = jq[0].val;
                void'(jq.pop_front());
            end
            chk("MonDReg", MonDReg, exp_mond);
            chk("MonAReg", {24'h0, MonAReg}, {24'h0, m_a});
            if (avs_read && !avs_waitrequest) begin
                if (cq.size() == 0) chk("cpu_unexpected_rd", 32'h1, 32'h0);
                else chk("avs_readdata", avs_readdata, cq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jload(input logic [7:0] addr, input bit rd);
        jdo = 38'h0;
        jdo[24:17] = addr;
        jdo[35] = rd;
        if (rd) jq.push_back('{cyc + 3, mm[addr]});
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        m_a = addr;
        if (rd) begin
            tick();
            m_a = m_a + 8'd1;
        end
    endtask

    task automatic jwrite(input logic [31:0] d);
        jdo = 38'h0;
        jdo[34:3] = d;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        mm[m_a] = d;
        m_a = m_a + 8'd1;
    endtask

    task automatic jread();
        jq.push_back('{cyc + 2, mm[m_a]});
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        m_a = m_a + 8'd1;
    endtask

    task automatic cpu_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] be);
        avs_address = addr; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        @(negedge clk);
        chk("cpu_wr_wait", {31'h0, avs_waitrequest}, 32'h0);
        tick();
        avs_write = 1'b0;
        for (int b = 0; b < 4; b++)
            if (be[b]) mm[addr] = (mm[addr] & ~(32'hFF << (8 * b))) | (d & (32'hFF << (8 * b)));
    endtask

    // jop: 0 none, 1 JTAG write in the first cycle, 2 pending read-after-load in the first cycle.
    task automatic cpu_read(input logic [7:0] addr, input int jop, input logic [31:0] jd, input int exp_waits);
        int waits = 0;
        bit done = 1'b0;
        if (jop == 1) begin
            jdo = 38'h0;
            jdo[34:3] = jd;
            take_action_ocimem_b = 1'b1;
            mm[m_a] = jd;
        end
        avs_address = addr;
        avs_read = 1'b1;
        cq.push_back(mm[addr]);
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (avs_waitrequest) waits++;
            else done = 1'b1;
            tick();
            if (i == 0) begin
                take_action_ocimem_b = 1'b0;
                if (jop != 0) m_a = m_a + 8'd1;
            end
        end
        avs_read = 1'b0;
        chk("cpu_rd_done", {31'h0, done}, 32'h1);
        chk("cpu_rd_waits", waits, exp_waits);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        jq.delete();
        cq.delete();
        exp_mond = 32'h0;
        m_a = 8'h00;
        mon_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; jdo = 38'h0;
        take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        avs_address = 8'h0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = 32'h0; avs_byteenable = 4'h0;
        m_a = 8'h00; exp_mond = 32'h0;
        tick(); tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_MonDReg", MonDReg, 32'h0);
        chk("rst_MonAReg", {24'h0, MonAReg}, 32'h0);
        chk("rst_waitreq", {31'h0, avs_waitrequest}, 32'h0);
        chk("rst_readdata", avs_readdata, 32'h0);
        tick();
        mon_en = 1'b1;

        // Zero background over the whole RAM; the address counter wraps back to 0.
        jload(8'h00, 1'b0);
        for (int i = 0; i < 256; i++) jwrite(32'h0);

        jload(8'h10, 1'b0);
        jwrite(32'hDEADBEEF);
        jwrite(32'h12345678);
        jload(8'h10, 1'b1);
        tick();
        jread();
        tick(); tick();
        chk("tp1_MonAReg", {24'h0, MonAReg}, 32'h12);

        jload(8'hFF, 1'b0);
        jwrite(32'hA5A5A5A5);
        chk("tp2_wrap", {24'h0, MonAReg}, 32'h00);
        jload(8'hFF, 1'b0);
        jread();
        tick(); tick();

        cpu_write(8'h03, 32'h11223344, 4'b0101);
        cpu_read(8'h03, 0, 32'h0, 1);

        jload(8'h20, 1'b0);
        cpu_read(8'h20, 1, 32'hCAFEF00D, 2);

        // CPU read colliding with a pending read-after-load.
        jdo = 38'h0; jdo[24:17] = 8'h10; jdo[35] = 1'b1;
        jq.push_back('{cyc + 3, mm[8'h10]});
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        m_a = 8'h10;
        cpu_read(8'h03, 2, 32'h0, 2);
        tick(); tick();

        jload(8'h40, 1'b0);
        jread();
        do_reset();
        @(negedge clk);
        chk("mid_rst_MonDReg", MonDReg, 32'h0);
        chk("mid_rst_MonAReg", {24'h0, MonAReg}, 32'h0);
        chk("mid_rst_waitreq", {31'h0, avs_waitrequest}, 32'h0);
        tick(); tick();

        jload(8'h33, 1'b0);
        tick(); tick(); tick();

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0: jload(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                1: jwrite($urandom);
                2: jread();
                3: cpu_write(8'($urandom_range(0, 255)), $urandom, 4'($urandom_range(0, 15)));
                4: cpu_read(8'($urandom_range(0, 255)), 0, 32'h0, 1);
                default: tick();
            endcase
        end
        tick(); tick(); tick();
        chk("jtag_queue_empty", jq.size(), 32'h0);
        chk("cpu_queue_empty", cq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
